branch_resolution_controller: RTL

Sequences the branch predictor across fetch and execute. At fetch it decodes `branch_type`, looks up a 2-bit saturating counter table and issues the prediction. It also queues each conditional prediction in an in-order in-flight FIFO. At resolution it retires the oldest entry, updates the counter, and on a mismatch raises a one-cycle mispredict and flushes all younger predictions.

---
 rtl/branch_resolution_controller.sv | 123 ++++++++++++
 1 files changed

// File: rtl/branch_resolution_controller.sv
// branch_resolution_controller: 2-bit saturating-counter predictor with an
// in-order in-flight FIFO of conditional predictions and mispredict recovery.
// Optional build macro: BRANCH_PREDICTOR_STATS_EN adds retire/mispredict
// statistics counters and their output ports.
module branch_resolution_controller #(
  parameter int INDEX_W = 4,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_valid,
  input  logic [2:0]         branch_type,
  input  logic [INDEX_W-1:0] fetch_index,
  input  logic               resolve_valid,
  input  logic               resolve_taken,
  output logic               predict_taken,
  output logic               unconditional_jump,
  output logic               fetch_stall,
  output logic               mispredict,
  output logic               resolve_underflow
`ifdef BRANCH_PREDICTOR_STATS_EN
  ,
  output logic [15:0]        stat_branches,
  output logic [15:0]        stat_mispredicts
`endif
);

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRIES = 1 << INDEX_W;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic [INDEX_W-1:0] idx;
    logic               pred;
  } entry_t;

  typedef enum logic {RUN, RECOVER} state_t;

  state_t             state;
  logic [1:0]         ctr  [ENTRIES];
  entry_t             fifo [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [PTR_W:0]     count;

  logic   conditional, run, empty, full, pop, push, miss;
  entry_t head;

  // Decode, lookup, and FIFO handshake; lookup reads the pre-update counter.
  always_comb begin
    conditional        = fetch_valid & (branch_type inside {3'b101, 3'b110, 3'b111});
    unconditional_jump = fetch_valid & (branch_type == 3'b100);
    predict_taken      = conditional & ctr[fetch_index][1];
    run                = (state == RUN);
    empty              = (count == '0);
    full               = (count == FULL_CNT);
    head               = fifo[rd_ptr];
    pop                = resolve_valid & ~empty & run;
    miss               = pop & (head.pred != resolve_taken);
    fetch_stall        = (conditional & full & ~pop) | ~run;
    push               = conditional & ~fetch_stall;
  end

  // FSM, FIFO pointers/occupancy and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= RUN;
      rd_ptr            <= '0;
      wr_ptr            <= '0;
      count             <= '0;
      mispredict        <= 1'b0;
      resolve_underflow <= 1'b0;
    end else begin
      mispredict <= miss;
      if (resolve_valid & empty & run) resolve_underflow <= 1'b1;
      case (state)
        RUN:     if (miss) state <= RECOVER;
        default: state <= RUN;
      endcase
      // A mispredict flushes every younger entry, including a same-cycle push.
      if (miss) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
      end
    end
  end

  // FIFO payload storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (push & ~miss) fifo[wr_ptr] <= '{idx: fetch_index, pred: predict_taken};
  end

  // Counter table: trains the retiring entry's counter with saturation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
    end else if (pop) begin
      if (resolve_taken) begin
        if (ctr[head.idx] != 2'b11) ctr[head.idx] <= ctr[head.idx] + 2'b01;
      end else begin
        if (ctr[head.idx] != 2'b00) ctr[head.idx] <= ctr[head.idx] - 2'b01;
      end
    end
  end

`ifdef BRANCH_PREDICTOR_STATS_EN
  // Saturating counts of retired branches and mispredicting retires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (pop  && stat_branches    != 16'hFFFF) stat_branches    <= stat_branches + 16'd1;
      if (miss && stat_mispredicts != 16'hFFFF) stat_mispredicts <= stat_mispredicts + 16'd1;
    end
  end
`endif

endmodule
